banked_mem_responder: RTL and testbench
=======================================

Name: banked_mem_responder

Overview:
- Four-bank, word-interleaved backing memory that answers the cache controller's memory-side requests: `rd`/`wr` plus `addr`/`data_in` in, `data_out`/`stall`/`busy`/`err` out.
- Bank = word address modulo 4, so a block's four words land in four different banks.
- Each bank is occupied for BANK_CYCLES after accepting an access.
- Read data returns a fixed READ_LAT cycles after acceptance, so a requester can issue one word per cycle across banks and drain data two cycles later.

Parameters:
- MEM_WORDS, 32768, number of 16-bit words stored (byte address space 2*MEM_WORDS).
- BANK_CYCLES, 4, cycles a bank stays occupied per accepted access, including the accept cycle.
- READ_LAT, 2, cycles from read acceptance to `data_out` valid.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- createdump  input  1  dump request; ignored by logic, kept for interface compatibility.
- addr  input  16  byte address; bank = addr[2:1], word index = addr[15:1].
- data_in  input  16  write data.
- rd  input  1  read request.
- wr  input  1  write request.
- data_out  output  16  read data, valid exactly READ_LAT cycles after read acceptance, otherwise 0.
- stall  output  1  combinational; request present this cycle but target bank occupied, so not accepted.
- busy  output  4  per-bank occupied flags, registered.
- err  output  1  protocol error flag, registered.

Behaviour:
- Reset (rst_n low, asynchronous): busy=0, data_out=0, err=0, read pipeline cleared, pending reads dropped and never returned. Storage contents are not reset.
- Request present = rd|wr. Target bank b = addr[2:1].
- stall = request & busy[b]. A stalled request is not accepted; the requester holds it and retries.
- Accept when request & !busy[b]:
  - Write: storage[addr[15:1]] <= data_in at that clock edge.
  - Read: address enters the READ_LAT pipeline.
- Per-bank countdown (2-bit when BANK_CYCLES=4):
  - Accept at cycle t loads BANK_CYCLES-1.
  - busy[b]=1 during cycles t+1 .. t+BANK_CYCLES-1.
  - The bank may accept again at cycle t+BANK_CYCLES.
- Independent banks accept on consecutive cycles, e.g. banks 0,1,2,3 at t..t+3 with no stall.
- Read path: read accepted at t drives data_out with the word stored as of the end of cycle t during cycle t+READ_LAT. data_out is 0 in cycles with no returning read.
- Reads back-to-back to different banks return back-to-back data, in order.
- Same-bank read-after-write: the read is blocked by busy and always returns new data.

Optional Feature:
- Macro: MEM_ERR_CHECK_EN.
- Defined — err is set (registered, one cycle) for any of:
  - rd & wr together;
  - request with addr[0]=1;
  - request with addr[15:1] >= MEM_WORDS.
  The offending request is not accepted: no storage change, no busy, no returned data, stall=0.
- Undefined: err tied 0, addr[0] ignored, rd&wr together treated as write only.

Decomposition:
- Package mem_bank_pkg holds NUM_BANKS=4, BANK_SEL_LSB=1, BANK_SEL_W=2, the default BANK_CYCLES and READ_LAT, and the word/address width constants.
- One sub-module, mem_bank, instantiated 4x. It owns the storage slice (MEM_WORDS/4 words), the busy countdown, and accept/write logic for one bank.
- Top level does bank decode, stall mux, read pipeline and the err register.

Test Plan:
- Reset → idle: assert rst_n=0 mid-cycle with a read in flight → busy=0, data_out=0, err=0 immediately; no data is ever returned for the dropped read.
- Single word: write 0xBEEF at addr 0x0010; wait 4 cycles; read 0x0010 at cycle t → stall=0, data_out=0xBEEF at t+2, and 0 at t+1 and t+3.
- Block burst: write 0x1111/0x2222/0x3333/0x4444 to 0x0100/0x0102/0x0104/0x0106. Read all four on consecutive cycles t..t+3 → no stall; data in the same order at t+2..t+5; busy shows 4'b0001,0011,0111,1110 progression.
- Bank conflict: read 0x0200 at t, then read 0x0208 (same bank 0) from t+1 → stall=1 at t+1..t+3; accepted at t+4; its data appears at t+6.
- Write then read same bank: write 0xA5A5 to 0x0300 at t, read 0x0300 at t+1 → stalls until t+4; data_out=0xA5A5 at t+6.
- MEM_ERR_CHECK_EN defined: rd=wr=1 at 0x0040, then rd at 0x0041 → err=1 the following cycle for each; busy stays 0; no data returned; storage unchanged on a subsequent legal read.

Source files
------------

// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg
//   Shared constants and types for the four-bank word-interleaved backing
//   memory (banked_mem_responder and its per-bank mem_bank instances).
package mem_bank_pkg;

    localparam int NUM_BANKS       = 4;
    localparam int BANK_SEL_LSB    = 1;      // addr[0] is the byte offset
    localparam int BANK_SEL_W      = 2;
    localparam int WORD_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int MEM_WORDS_DEF   = 32768;
    localparam int BANK_CYCLES_DEF = 4;
    localparam int READ_LAT_DEF    = 2;

    typedef logic [WORD_W-1:0] word_t;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic  vld;
        word_t data;
    } rd_slot_t;

    // Counter width able to hold n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bank.sv
// mem_bank
//   One bank of the interleaved memory: storage slice, occupancy countdown
//   and write port. The parent only raises acc_i when the bank is idle.
// Ports:
//   clk, rst_n   clock, async active-low reset (storage is not reset)
//   acc_i        access accepted this cycle
//   we_i         accepted access is a write
//   idx_i        word index inside this bank
//   wdata_i      write data
//   rdata_o      combinational read of storage at idx_i
//   busy_o       registered occupied flag
module mem_bank import mem_bank_pkg::*; #(
    parameter int DEPTH       = MEM_WORDS_DEF / NUM_BANKS,
    parameter int BANK_CYCLES = BANK_CYCLES_DEF,
    localparam int IDX_W      = (DEPTH < 2) ? 1 : $clog2(DEPTH),
    localparam int CW         = cnt_w(BANK_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic             busy_o
);

    word_t         mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q;

    // Accept loads BANK_CYCLES-1 so the bank is busy for the following
    // BANK_CYCLES-1 cycles and free again at t+BANK_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_i)
            cnt_d = CW'(BANK_CYCLES - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (acc_i && we_i)
            mem_q[idx_i] <= wdata_i;
    end

    // A read accepted in cycle t samples here before the edge; no write to
    // this bank can land in the same cycle, so this is the end-of-t value.
    assign rdata_o = mem_q[idx_i];
    assign busy_o  = busy_q;

endmodule

// File: rtl/banked_mem_responder.sv
// banked_mem_responder
//   Four-bank word-interleaved backing memory answering cache memory-side
//   requests. Bank = addr[2:1]; each bank is occupied BANK_CYCLES per access;
//   read data returns exactly READ_LAT cycles after acceptance.
//   Optional macro MEM_ERR_CHECK_EN: flags rd&wr, odd addresses and
//   out-of-range words on err (one registered cycle) and drops them.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   createdump   unused, kept for interface compatibility
//   addr         byte address
//   data_in      write data
//   rd, wr       read / write request
//   data_out     returning read data, 0 when nothing returns
//   stall        request present but target bank busy (combinational)
//   busy         per-bank occupied flags (registered)
//   err          protocol error flag (registered)
module banked_mem_responder import mem_bank_pkg::*; #(
    parameter int MEM_WORDS   = MEM_WORDS_DEF,
    parameter int BANK_CYCLES = BANK_CYCLES_DEF,
    parameter int READ_LAT    = READ_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 createdump,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 rd,
    input  logic                 wr,
    output logic [WORD_W-1:0]    data_out,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    localparam int BANK_DEPTH = MEM_WORDS / NUM_BANKS;
    localparam int IDX_W      = (BANK_DEPTH < 2) ? 1 : $clog2(BANK_DEPTH);

    logic                  req, illegal, acc, rd_acc;
    logic [BANK_SEL_W-1:0] bsel;
    logic [ADDR_W-2:0]     widx;
    logic [IDX_W-1:0]      bidx;
    logic [NUM_BANKS-1:0]  bank_busy;
    word_t                 bank_rdata [NUM_BANKS];
    logic                  unused_ok;

    assign req  = rd | wr;
    assign bsel = addr[BANK_SEL_LSB +: BANK_SEL_W];
    assign widx = addr[ADDR_W-1:1];
    assign bidx = widx[BANK_SEL_W +: IDX_W];

`ifdef MEM_ERR_CHECK_EN
    assign illegal = (rd & wr) | addr[0] | ({17'b0, widx} >= 32'(MEM_WORDS));
`else
    assign illegal = 1'b0;
`endif

    // Illegal requests are dropped outright and never stall.
    assign acc    = req & ~illegal & ~bank_busy[bsel];
    assign stall  = req & ~illegal &  bank_busy[bsel];
    assign rd_acc = acc & ~wr;          // rd&wr without checking = write
    assign busy   = bank_busy;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DEPTH       (BANK_DEPTH),
            .BANK_CYCLES (BANK_CYCLES)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .acc_i   (acc && (bsel == BANK_SEL_W'(g))),
            .we_i    (wr),
            .idx_i   (bidx),
            .wdata_i (data_in),
            .rdata_o (bank_rdata[g]),
            .busy_o  (bank_busy[g])
        );
    end

    // Fixed-latency read return: slot 0 captures at acceptance, the last
    // slot drives data_out.
    rd_slot_t pipe_q [READ_LAT];
    rd_slot_t pipe_d [READ_LAT];

    always_comb begin
        pipe_d[0].vld  = rd_acc;
        pipe_d[0].data = rd_acc ? bank_rdata[bsel] : '0;
        for (int i = 1; i < READ_LAT; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++)
                pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < READ_LAT; i++)
                pipe_q[i] <= pipe_d[i];
        end
    end

    assign data_out = pipe_q[READ_LAT-1].vld ? pipe_q[READ_LAT-1].data : '0;

`ifdef MEM_ERR_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= req & illegal;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign unused_ok = ^{createdump, addr, widx};

endmodule

// File: tb/tb_banked_mem_responder.sv
module tb_banked_mem_responder;

    localparam int MEM_WORDS   = 32768;
    localparam int BANK_CYCLES = 4;
    localparam int READ_LAT    = 2;

    logic        clk = 1'b0, rst_n = 1'b0, createdump = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [15:0] addr = '0, data_in = '0;
    logic [15:0] data_out;
    logic        stall, err;
    logic [3:0]  busy;

    banked_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .BANK_CYCLES(BANK_CYCLES), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .createdump(createdump), .addr(addr),
        .data_in(data_in), .rd(rd), .wr(wr), .data_out(data_out),
        .stall(stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;

    // Reference model: word storage, cycle at which each bank is free again,
    // and the data expected on data_out keyed by cycle number.
    logic [15:0] mem_m [int];
    logic [15:0] ret_m [int];
    int          bank_free [4];
    bit          err_m;

    logic [15:0] last_dout;
    logic        last_stall, last_err;
    logic [3:0]  last_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
        bit          rq, ill, st;
        int          b, wi;
        logic [3:0]  eb;
        logic [15:0] ed;
        @(negedge clk);
        cyc++;
        rd = r; wr = w; addr = a; data_in = d;
        #1;
        rq = r | w;
        b  = int'(a[2:1]);
        wi = int'(a[15:1]);
`ifdef MEM_ERR_CHECK_EN
        ill = (r && w) || a[0] || (wi >= MEM_WORDS);
`else
        ill = 1'b0;
`endif
        st = rq && !ill && (cyc < bank_free[b]);
        for (int i = 0; i < 4; i++) eb[i] = (cyc < bank_free[i]);
        ed = ret_m.exists(cyc) ? ret_m[cyc] : 16'h0;
        chk("stall", {31'b0, stall}, {31'b0, st});
        chk("busy", {28'b0, busy}, {28'b0, eb});
        chk("data_out", {16'b0, data_out}, {16'b0, ed});
        chk("err", {31'b0, err}, {31'b0, err_m});
        last_dout = data_out; last_stall = stall; last_busy = busy; last_err = err;
        if (rq && !ill && !st) begin
            bank_free[b] = cyc + BANK_CYCLES;
            if (w) mem_m[wi] = d;
            else   ret_m[cyc + READ_LAT] = mem_m.exists(wi) ? mem_m[wi] : 16'h0;
        end
        err_m = rq && ill;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Hold a request until accepted; returns the number of stalled cycles.
    task automatic req_hold(input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] d, output int nst);
        nst = 0;
        step(r, w, a, d);
        while (last_stall && nst < 16) begin
            nst++;
            step(r, w, a, d);
        end
        if (last_stall) chk("hold_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int          ns;
        logic [15:0] bd [6];
        logic [3:0]  bb [6];
        logic        bs [6];
        logic [15:0] ra, rdat;
        bit          rr, rw;

        for (int i = 0; i < 4; i++) bank_free[i] = 0;
        err_m = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {28'b0, busy}, 32'h0);
        chk("rst_dout", {16'b0, data_out}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst_n = 1'b1;

        // Preload words 0..63 (bytes 0x00..0x7E)
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 16'(i * 2), 16'($urandom));

        // Single word
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(4);
        step(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("sw_stall", {31'b0, last_stall}, 32'h0);
        idle(1); chk("sw_t1", {16'b0, last_dout}, 32'h0);
        idle(1); chk("sw_t2", {16'b0, last_dout}, 32'hBEEF);
        idle(1); chk("sw_t3", {16'b0, last_dout}, 32'h0);

        // Block burst
        step(1'b0, 1'b1, 16'h0100, 16'h1111);
        step(1'b0, 1'b1, 16'h0102, 16'h2222);
        step(1'b0, 1'b1, 16'h0104, 16'h3333);
        step(1'b0, 1'b1, 16'h0106, 16'h4444);
        idle(4);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) step(1'b1, 1'b0, 16'(16'h0100 + 2 * k), 16'h0);
            else       idle(1);
            bd[k] = last_dout; bb[k] = last_busy; bs[k] = last_stall;
        end
        chk("bb_nostall", {28'b0, bs[0], bs[1], bs[2], bs[3]}, 32'h0);
        chk("bb_busy1", {28'b0, bb[1]}, 32'h1);
        chk("bb_busy2", {28'b0, bb[2]}, 32'h3);
        chk("bb_busy3", {28'b0, bb[3]}, 32'h7);
        chk("bb_busy4", {28'b0, bb[4]}, 32'hE);
        chk("bb_d0", {16'b0, bd[2]}, 32'h1111);
        chk("bb_d1", {16'b0, bd[3]}, 32'h2222);
        chk("bb_d2", {16'b0, bd[4]}, 32'h3333);
        chk("bb_d3", {16'b0, bd[5]}, 32'h4444);

        // Bank conflict
        req_hold(1'b0, 1'b1, 16'h0200, 16'h0C01, ns);
        req_hold(1'b0, 1'b1, 16'h0208, 16'h0C02, ns);
        idle(4);
        step(1'b1, 1'b0, 16'h0200, 16'h0);
        req_hold(1'b1, 1'b0, 16'h0208, 16'h0, ns);
        chk("cf_stalls", 32'(ns), 32'd3);
        idle(2);
        chk("cf_data", {16'b0, last_dout}, 32'h0C02);

        // Write then read, same bank
        idle(4);
        step(1'b0, 1'b1, 16'h0300, 16'hA5A5);
        req_hold(1'b1, 1'b0, 16'h0300, 16'h0, ns);
        chk("raw_stalls", 32'(ns), 32'd3);
        idle(2);
        chk("raw_data", {16'b0, last_dout}, 32'hA5A5);

        // Protocol-error cases (dropped when checking is built in)
        idle(4);
        step(1'b1, 1'b1, 16'h0040, 16'h7777);
        idle(1);
`ifdef MEM_ERR_CHECK_EN
        chk("e_rdwr_err", {31'b0, last_err}, 32'h1);
        chk("e_rdwr_busy", {28'b0, last_busy}, 32'h0);
`endif
        idle(4);
        step(1'b1, 1'b0, 16'h0041, 16'h0);
        idle(1);
`ifdef MEM_ERR_CHECK_EN
        chk("e_odd_err", {31'b0, last_err}, 32'h1);
        chk("e_odd_busy", {28'b0, last_busy}, 32'h0);
`endif
        idle(4);
        step(1'b1, 1'b0, 16'h0040, 16'h0);
        idle(2);

        // Randomized traffic
        rr = 1'b0; rw = 1'b0; ra = '0; rdat = '0;
        for (int i = 0; i < 500; i++) begin
            if (!(last_stall && ($urandom_range(0, 3) != 0))) begin
                rr   = $urandom_range(0, 1) == 1;
                rw   = !rr && ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 3) == 0) begin rr = 1'b0; rw = 1'b0; end
                if ($urandom_range(0, 31) == 0) begin rr = 1'b1; rw = 1'b1; end
                ra   = 16'($urandom_range(0, 63) * 2);
                if ($urandom_range(0, 31) == 0) ra[0] = 1'b1;
                rdat = 16'($urandom);
            end
            step(rr, rw, ra, rdat);
        end
        idle(4);

        // Reset with a read in flight: dropped, never returned
        step(1'b1, 1'b0, 16'h0010, 16'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", {28'b0, busy}, 32'h0);
        chk("ar_dout", {16'b0, data_out}, 32'h0);
        chk("ar_err", {31'b0, err}, 32'h0);
        ret_m.delete();
        for (int i = 0; i < 4; i++) bank_free[i] = 0;
        err_m = 1'b0;
        #1 rst_n = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
